pla_t4_bist_ctrl: RTL
=====================

Name: pla_t4_bist_ctrl

Overview:
- Sequential stimulus-and-compaction stage wrapped around the 12-in/8-out t4 PLA.
- Drives the PLA input bus x00..x11 from a registered vector generator and consumes z0..z7 one cycle later.
- Compacts the responses into a MISR signature and flags pass/fail against a supplied golden signature.
- Used for exhaustive self-test of the two-level logic block in silicon and in regression.

Parameters:
- VEC_W, 12, PLA input width; the sweep covers 2^VEC_W vectors.
- OUT_W, 8, PLA output width compacted per cycle; must be <= SIG_W.
- SIG_W, 16, MISR width.
- MISR_POLY, 16'h1021, MISR feedback polynomial without the x^16 term.
- MISR_SEED, 16'hFFFF, MISR value loaded on start.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- start  in  1  one-cycle pulse; honoured in IDLE or DONE only.
- abort  in  1  returns the block to IDLE from any state.
- stall  in  1  freezes generator, capture pipe and MISR while high.
- x_out  out  VEC_W  registered PLA input vector.
- z_in  in  OUT_W  PLA response to the x_out value of the previous cycle.
- expected_sig  in  SIG_W  golden signature, quasi-static.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.
- pass  out  1  (signature == expected_sig) while in DONE, else 0.
- signature  out  SIG_W  current MISR contents.
- vec_count  out  VEC_W+1  number of responses compacted.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state IDLE; x_out=0, busy=0, done=0, pass=0, signature=MISR_SEED, vec_count=0.
- IDLE→RUN on start: same edge sets MISR=MISR_SEED, vec_count=0, gen=0, cap_vld=0.
- RUN, stall=0, each cycle:
  - x_out<=gen; cap_vld<=1; gen advances.
  - If cap_vld=1, then MISR<=shift(MISR) ^ zero-extended z_in, and vec_count++.
- MISR shift: shift(s) = {s[SIG_W-2:0],1'b0} ^ (s[SIG_W-1] ? MISR_POLY : 0).
- Counter mode: gen runs 0..2^VEC_W-1.
- RUN→DRAIN on the cycle the last vector is issued on x_out.
- DRAIN: compacts the final response; the next cycle is DONE.
- Latency and counts:
  - The first x_out is valid 1 cycle after start.
  - The first compaction happens 2 cycles after start.
  - Exactly 2^VEC_W compactions occur in total.
  - DONE is reached 2^VEC_W+2 cycles after start when there are no stalls.
- DONE:
  - x_out, signature and vec_count are held.
  - done=1.
  - pass is combinational on signature vs expected_sig.
  - start restarts the run as from IDLE.
- stall:
  - Every register holds, including cap_vld; no vector is skipped or duplicated.
  - A stall in DRAIN delays DONE.
  - stall has no effect in IDLE and DONE.
- abort (priority over start and stall): next state IDLE, x_out=0, cap_vld=0, busy=0, done=0. signature and vec_count keep their last values for debug.
- start while busy is ignored.
- rst asserted mid-run: all outputs take their reset values on the next edge, whatever the state.
- Wrap: the generator never wraps inside a run; the terminal vector triggers DRAIN.

Optional Feature:
- Macro: PLA_BIST_LFSR_EN.
- Defined:
  - Generator is a VEC_W-bit Fibonacci LFSR, x^12+x^6+x^4+x+1, seeded 12'h001.
  - It issues 4095 LFSR states followed by 12'h000, for 2^VEC_W vectors in total, with identical timing.
  - The DRAIN trigger is the 12'h000 vector.
- Undefined: ascending binary counter. Port list is identical in both builds.

Decomposition:
- Shared package pla_bist_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - MISR_POLY_DEFAULT, MISR_SEED_DEFAULT and the LFSR tap mask;
  - a shift function used by both the RTL and the bench model.
- One sub-module, pla_bist_misr: SIG_W-wide MISR with enable, load-seed and data input.
- The FSM and generator stay in the top module.

Test Plan:
- Counter mode, z_in driven by a behavioural t4 model, start pulse:
  - x_out = 0x000 at cycle 1 and 0xFFF at cycle 4096;
  - done at cycle 4098 with vec_count = 4096;
  - signature equals the package-function model.
- Tie z_in = 8'h00: signature equals MISR_SEED shifted 4096 times by the model. With expected_sig equal to that value pass=1; with it XOR 16'h0001 pass=0.
- Stall pulses of 3 cycles every 100 cycles: signature identical to the unstalled run; DONE delayed by exactly the stalled cycle count.
- abort at vector 100:
  - busy=0 and x_out=0 next cycle;
  - signature and vec_count (=99) held;
  - a later start gives the same result as a clean run.
- rst at cycle 500, then start: outputs at reset values; full run reproduces the golden signature.
- PLA_BIST_LFSR_EN build:
  - first vectors 0x001, 0x002, 0x004…;
  - last vector 0x000;
  - 4096 distinct vectors observed and done at cycle 4098.

Source files
------------

// File: rtl/pla_bist_pkg.sv
// Shared definitions for the t4 PLA self-test controller: FSM state encoding,
// default MISR polynomial/seed, the 12-bit LFSR tap mask and the MISR shift
// function. The function is also used by the testbench signature model.
package pla_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } bist_state_t;

    localparam int          MISR_W            = 16;
    localparam logic [15:0] MISR_POLY_DEFAULT = 16'h1021;
    localparam logic [15:0] MISR_SEED_DEFAULT = 16'hFFFF;

    // Left-shifting Fibonacci LFSR, new bit enters at bit 0.
    // Feedback from bits 11,10,7,5 realises x^12+x^6+x^4+x+1.
    localparam logic [11:0] LFSR_TAPS = 12'hCA0;
    localparam logic [11:0] LFSR_SEED = 12'h001;

    // One MISR shift step (no data injection).
    function automatic logic [15:0] misr_shift(input logic [15:0] s, input logic [15:0] poly);
        return {s[14:0], 1'b0} ^ (s[15] ? poly : 16'h0000);
    endfunction

endpackage

// File: rtl/pla_bist_misr.sv
// Multiple-input signature register: loads the seed on request, otherwise
// shifts and folds in the data word whenever enabled.
module pla_bist_misr
    import pla_bist_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(MISR_POLY_DEFAULT),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(MISR_SEED_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [SIG_W-1:0] din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_reg;
    logic [SIG_W-1:0] shifted;

    // The shared package function covers the standard width; other widths
    // use the same recurrence written generically.
    generate
        if (SIG_W == MISR_W) begin : g_pkg_shift
            assign shifted = misr_shift(sig_reg, POLY);
        end else begin : g_gen_shift
            assign shifted = {sig_reg[SIG_W-2:0], 1'b0} ^ (sig_reg[SIG_W-1] ? POLY : '0);
        end
    endgenerate

    // Signature register: reset/load to seed, compaction when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_reg <= SEED;
        end else if (load) begin
            sig_reg <= SEED;
        end else if (en) begin
            sig_reg <= shifted ^ din;
        end
    end

    assign sig = sig_reg;

endmodule

// File: rtl/pla_t4_bist_ctrl.sv
// Exhaustive self-test wrapper for the 12-in/8-out t4 PLA: a registered
// vector generator drives x_out, the response z_in (one cycle later) is
// compacted into a MISR, and pass compares the final signature with
// expected_sig.
// Build option PLA_BIST_LFSR_EN: the generator becomes a 12-bit LFSR that
// issues 4095 LFSR states followed by 12'h000; otherwise it is a binary
// counter 0..2^VEC_W-1. Ports and timing are identical in both builds.
module pla_t4_bist_ctrl
    import pla_bist_pkg::*;
#(
    parameter int               VEC_W     = 12,
    parameter int               OUT_W     = 8,
    parameter int               SIG_W     = 16,
    parameter logic [SIG_W-1:0] MISR_POLY = SIG_W'(MISR_POLY_DEFAULT),
    parameter logic [SIG_W-1:0] MISR_SEED = SIG_W'(MISR_SEED_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             stall,
    output logic [VEC_W-1:0] x_out,
    input  logic [OUT_W-1:0] z_in,
    input  logic [SIG_W-1:0] expected_sig,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature,
    output logic [VEC_W:0]   vec_count
);

    localparam logic [VEC_W-1:0] GEN_ONE = {{(VEC_W-1){1'b0}}, 1'b1};
    localparam logic [VEC_W:0]   CNT_ONE = {{VEC_W{1'b0}}, 1'b1};

`ifdef PLA_BIST_LFSR_EN
    localparam logic [VEC_W-1:0] GEN_SEED = VEC_W'(LFSR_SEED);
    localparam logic [VEC_W-1:0] GEN_LAST = '0;
    localparam logic [VEC_W-1:0] TAP_MASK = VEC_W'(LFSR_TAPS);
`else
    localparam logic [VEC_W-1:0] GEN_SEED = '0;
    localparam logic [VEC_W-1:0] GEN_LAST = '1;
`endif

    bist_state_t      state_reg, state_next;
    logic [VEC_W-1:0] gen_reg, gen_next, gen_adv;
    logic [VEC_W-1:0] x_out_reg, x_out_next;
    logic             cap_vld_reg, cap_vld_next;
    logic [VEC_W:0]   vec_count_reg, vec_count_next;
    logic             misr_en, misr_load;
    logic [SIG_W-1:0] misr_din;

`ifdef PLA_BIST_LFSR_EN
    logic [VEC_W-1:0] lfsr_step;

    // LFSR advance; once the sequence would return to the seed, emit the
    // all-zero vector instead, which also serves as the terminal vector.
    always_comb begin
        lfsr_step = {gen_reg[VEC_W-2:0], ^(gen_reg & TAP_MASK)};
        gen_adv   = (lfsr_step == GEN_SEED) ? '0 : lfsr_step;
    end
`else
    // Binary counter advance.
    always_comb begin
        gen_adv = gen_reg + GEN_ONE;
    end
`endif

    // Zero-extend the PLA response to the MISR width.
    generate
        for (genvar gi = 0; gi < SIG_W; gi++) begin : g_din
            if (gi < OUT_W) begin : g_bit
                assign misr_din[gi] = z_in[gi];
            end else begin : g_pad
                assign misr_din[gi] = 1'b0;
            end
        end
    endgenerate

    // State, generator, vector output, capture flag and compaction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            gen_reg       <= GEN_SEED;
            x_out_reg     <= '0;
            cap_vld_reg   <= 1'b0;
            vec_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            gen_reg       <= gen_next;
            x_out_reg     <= x_out_next;
            cap_vld_reg   <= cap_vld_next;
            vec_count_reg <= vec_count_next;
        end
    end

    // Next-state logic. DRAIN first flushes the pending capture, then spends
    // one quiet cycle so the signature is stable before done rises.
    always_comb begin
        state_next     = state_reg;
        gen_next       = gen_reg;
        x_out_next     = x_out_reg;
        cap_vld_next   = cap_vld_reg;
        vec_count_next = vec_count_reg;
        misr_en        = 1'b0;
        misr_load      = 1'b0;

        if (abort) begin
            // Signature and count are left untouched for debug.
            state_next   = IDLE;
            x_out_next   = '0;
            cap_vld_next = 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_next     = RUN;
                        misr_load      = 1'b1;
                        vec_count_next = '0;
                        gen_next       = GEN_SEED;
                        cap_vld_next   = 1'b0;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        x_out_next   = gen_reg;
                        cap_vld_next = 1'b1;
                        gen_next     = gen_adv;
                        if (cap_vld_reg) begin
                            misr_en        = 1'b1;
                            vec_count_next = vec_count_reg + CNT_ONE;
                        end
                        if (gen_reg == GEN_LAST) begin
                            state_next = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!stall) begin
                        if (cap_vld_reg) begin
                            misr_en        = 1'b1;
                            vec_count_next = vec_count_reg + CNT_ONE;
                            cap_vld_next   = 1'b0;
                        end else begin
                            state_next = DONE;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    pla_bist_misr #(
        .SIG_W (SIG_W),
        .POLY  (MISR_POLY),
        .SEED  (MISR_SEED)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .load (misr_load),
        .en   (misr_en),
        .din  (misr_din),
        .sig  (signature)
    );

    assign x_out     = x_out_reg;
    assign vec_count = vec_count_reg;
    assign busy      = (state_reg == RUN) || (state_reg == DRAIN);
    assign done      = (state_reg == DONE);
    assign pass      = done && (signature == expected_sig);

endmodule
